// File: rtl/motor_pkg.sv
// Types and defaults shared by the motor MMIO handler and the per-axis step generators.
package motor_pkg;

    localparam int MOTOR_CNT_W   = 32;
    localparam int DEF_STEP_HIGH = 50;
    localparam int DEF_STEP_LOW  = 50;
    localparam int DEF_DIR_SETUP = 10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } state_t;

endpackage

// File: rtl/stepper_step_gen.sv
// Per-axis STEP/DIR pulse generator: turns a step count and direction into timed
// driver pulses and reports the live remaining count back to the MMIO handler.
module stepper_step_gen
    import motor_pkg::*;
#(
    parameter int CNT_W     = MOTOR_CNT_W,
    parameter int TMR_W     = 16,
    parameter int STEP_HIGH = DEF_STEP_HIGH,
    parameter int STEP_LOW  = DEF_STEP_LOW,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             load,
    input  logic [CNT_W-1:0] step_count,
    input  logic             dir,
    input  logic             halt,
    output logic             step_out,
    output logic             dir_out,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             halted
);

    localparam longint TMR_MAX = (64'(1) << TMR_W) - 1;

    if (STEP_HIGH < 1 || STEP_LOW < 1 || DIR_SETUP < 1 ||
        STEP_HIGH > TMR_MAX || STEP_LOW > TMR_MAX || DIR_SETUP > TMR_MAX) begin : g_param_check
        $error("stepper_step_gen: timing parameters must be in 1 .. 2**TMR_W-1");
    end

    localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] T_HIGH  = TMR_W'(STEP_HIGH - 1);
    localparam logic [TMR_W-1:0] T_LOW   = TMR_W'(STEP_LOW - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             moving;

    assign moving = (state == SETUP) || (state == HIGH) || (state == LOW);

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state     <= IDLE;
            timer     <= '0;
            step_out  <= 1'b0;
            dir_out   <= 1'b1;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            done <= 1'b0;
            // A new command always wins, even over halt and even mid-pulse.
            if (load) begin
                remaining <= step_count;
                dir_out   <= dir;
                step_out  <= 1'b0;
                halted    <= 1'b0;
                if (step_count == '0) begin
                    state <= DONE;
                    timer <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= SETUP;
                    timer <= T_SETUP;
                    busy  <= 1'b1;
                end
            end else if (halt && moving) begin
                state    <= IDLE;
                timer    <= '0;
                step_out <= 1'b0;
                busy     <= 1'b0;
                halted   <= 1'b1;
            end else begin
                case (state)
                    SETUP: begin
                        if (timer == '0) begin
                            state    <= HIGH;
                            step_out <= 1'b1;
                            timer    <= T_HIGH;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    HIGH: begin
                        if (timer == '0) begin
                            state     <= LOW;
                            step_out  <= 1'b0;
                            remaining <= remaining - CNT_W'(1);
                            timer     <= T_LOW;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    LOW: begin
                        if (timer == '0) begin
                            if (remaining != '0) begin
                                state    <= HIGH;
                                step_out <= 1'b1;
                                timer    <= T_HIGH;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/stepper_step_gen.md
Name: stepper_step_gen

Overview:
- Per-axis step/direction pulse generator; sits directly downstream of the APB motor MMIO handler. One instance is used per axis (x and y).
- Consumes the handler's signed-magnitude command: an unsigned step count and a direction bit.
- Produces timed STEP/DIR signals for the external stepper driver.
- Returns the live remaining count and direction to the handler's counter_in/dir_in inputs, plus a done strobe used for interrupt generation.

Parameters:
- CNT_W, 32, width of step count and remaining count.
- TMR_W, 16, width of the internal phase timer.
- STEP_HIGH, 50, PCLK cycles STEP is held high per step (>=1).
- STEP_LOW, 50, PCLK cycles STEP is held low per step (>=1).
- DIR_SETUP, 10, PCLK cycles DIR is stable before the first STEP rise after a load (>=1).

Ports:
- PCLK in 1 clock; all logic on its rising edge.
- PRESERN in 1 reset; asynchronous, active-low.
- load in 1 single-cycle command strobe from the MMIO handler (write to this axis).
- step_count in CNT_W number of steps to issue; unsigned magnitude.
- dir in 1 commanded direction (1 = forward).
- halt in 1 synchronous stop request (limit switch or e-stop, pre-synchronised).
- step_out out 1 STEP to the driver.
- dir_out out 1 DIR to the driver.
- remaining out CNT_W steps still to issue; feeds counter_in.
- busy out 1 high in SETUP, HIGH or LOW.
- done out 1 one-cycle strobe when a move completes normally.
- halted out 1 sticky flag: the move was stopped by halt.

Behaviour:
- Reset values: step_out=0, dir_out=1, remaining=0, busy=0, done=0, halted=0, state=IDLE, timer=0.
- States: IDLE, SETUP, HIGH, LOW, DONE. All outputs are registered.
- Load in any state (highest priority, overrides halt in the same cycle):
  - latch remaining<=step_count and dir_out<=dir; step_out<=0; halted<=0.
  - if step_count==0: go to DONE. Otherwise go to SETUP with timer=DIR_SETUP-1.
  - A load during HIGH aborts that pulse immediately. That step is not counted.
- SETUP: timer decrements each cycle. At timer==0, go to HIGH with step_out<=1 and timer=STEP_HIGH-1.
  - Result: the first STEP rise is DIR_SETUP cycles after the load edge.
- HIGH: at timer==0:
  - step_out<=0; remaining<=remaining-1.
  - go to LOW with timer=STEP_LOW-1.
  - remaining decrements exactly on each STEP fall.
- LOW: at timer==0:
  - if remaining!=0: go to HIGH with step_out<=1 and timer=STEP_HIGH-1.
  - if remaining==0: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. Total latency for N>0 steps: load edge to done high = DIR_SETUP + N*(STEP_HIGH+STEP_LOW) cycles.
- halt=1 in SETUP/HIGH/LOW with no load:
  - next state IDLE; step_out<=0.
  - remaining frozen; a STEP truncated in HIGH is not counted.
  - halted<=1; done is not asserted.
  - halt in IDLE or DONE has no effect; DONE still completes.
- dir_out changes only on load; it holds after completion and after halt.
- The remaining decrement never underflows: HIGH is entered only when remaining!=0.
- The timer reloads from parameters truncated to TMR_W. Parameters larger than 2^TMR_W-1 are illegal; flag with an elaboration-time check.
- Reset asserted mid-move: all outputs return to reset values immediately (asynchronously). STEP drops without completing its high time.

Decomposition:
- Shared package motor_pkg:
  - state enum (IDLE, SETUP, HIGH, LOW, DONE).
  - default timing constants (STEP_HIGH/LOW, DIR_SETUP).
  - CNT_W, shared with the MMIO handler.
- No sub-module needed. An optional phase_timer (load value, decrement, zero flag) may be factored out if reused by a future acceleration profiler.

Test Plan:
All scenarios use STEP_HIGH=2, STEP_LOW=3, DIR_SETUP=2.
- Reset:
  - Stimulus: drop PRESERN mid-HIGH of a move.
  - Required: step_out=0, dir_out=1, remaining=0, busy=0 without waiting for a clock edge.
- Basic move:
  - Stimulus: load, step_count=3, dir=0.
  - Required: dir_out=0 the next cycle; STEP rises 2 cycles after the load edge; 3 pulses, each 2 cycles high and 3 low.
  - Required: remaining steps 3→2→1→0, one per fall; done is a one-cycle strobe 17 cycles after load; busy is low afterwards.
- Zero count:
  - Stimulus: load with step_count=0.
  - Required: no STEP pulse; done the cycle after load; remaining=0.
- Reload mid-pulse:
  - Stimulus: during HIGH of step 2 of a 5-step move, load step_count=2, dir=1.
  - Required: STEP falls immediately; remaining=2; DIR setup restarts; exactly 2 further full pulses, then done.
- Halt:
  - Stimulus: assert halt in LOW after 2 of 5 steps.
  - Required: IDLE; remaining=3; halted=1; no done.
  - Stimulus: a following load.
  - Required: halted clears and the new move runs.
- Simultaneous load and halt:
  - Stimulus: load and halt in the same cycle.
  - Required: load wins; the move starts; halted=0.
